// File: rtl/fpu_two_over_pi_window.sv
// Streams consecutive WIN_W-bit windows of the first 256 fractional bits of 2/pi,
// starting at an arbitrary bit offset, with valid/ready backpressure on the output.
module fpu_two_over_pi_window #(
    parameter int unsigned WIN_W     = 64,
    parameter int unsigned MAX_WORDS = 4,
    parameter int unsigned OFS_W     = 9,
    parameter int unsigned CNT_W     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [OFS_W-1:0] req_offset,
    input  logic [CNT_W-1:0] req_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIN_W-1:0] out_data,
    output logic [CNT_W-1:0] out_index,
    output logic             out_last,
    output logic             out_past_end,
    output logic             busy
);

    localparam int unsigned TBL_W  = 256;
    localparam int unsigned EXT_W  = TBL_W + WIN_W;
    // One spare bit so offset + (MAX_WORDS-1)*WIN_W + WIN_W never wraps.
    localparam int unsigned ADDR_W = OFS_W + $clog2(MAX_WORDS * WIN_W) + 1;

    localparam logic [TBL_W-1:0] TWO_OVER_PI =
        256'hA2F9836E4E441529_FC2757D1F534DDC0_DB6295993C439041_FE5163ABDEBBC561;

    typedef enum logic {
        StIdle,
        StStream
    } state_e;

    state_e             r_state, w_state_d;
    logic [ADDR_W-1:0]  r_start, w_start_d;
    logic [CNT_W-1:0]   r_idx, w_idx_d;
    logic [CNT_W-1:0]   r_last_idx, w_last_idx_d;
    logic [WIN_W-1:0]   r_data, w_data_d;
    logic               r_last, w_last_d;
    logic               r_past_end, w_past_end_d;
    logic               w_load;
    logic [CNT_W-1:0]   w_eff_last;

    // Table followed by WIN_W zeros; shifting left by s puts position s at the top.
    function automatic logic [WIN_W-1:0] win_word(input logic [ADDR_W-1:0] s);
        logic [EXT_W-1:0] ext;
        ext = {TWO_OVER_PI, {WIN_W{1'b0}}};
        if (s >= ADDR_W'(TBL_W)) begin
            return '0;
        end
        ext = ext << s;
        return ext[EXT_W-1 -: WIN_W];
    endfunction

    always_comb begin
        if (req_count == '0) begin
            w_eff_last = '0;
        end else if (req_count > CNT_W'(MAX_WORDS)) begin
            w_eff_last = CNT_W'(MAX_WORDS - 1);
        end else begin
            w_eff_last = req_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_start_d    = r_start;
        w_idx_d      = r_idx;
        w_last_idx_d = r_last_idx;
        w_data_d     = r_data;
        w_last_d     = r_last;
        w_past_end_d = r_past_end;
        w_load       = 1'b0;

        case (r_state)
            StIdle: begin
                if (req_valid) begin
                    w_start_d    = ADDR_W'(req_offset);
                    w_idx_d      = '0;
                    w_last_idx_d = w_eff_last;
                    w_load       = 1'b1;
                    w_state_d    = StStream;
                end
            end
            StStream: begin
                if (out_ready) begin
                    if (r_last) begin
                        w_state_d = StIdle;
                    end else begin
                        w_start_d = r_start + ADDR_W'(WIN_W);
                        w_idx_d   = r_idx + CNT_W'(1);
                        w_load    = 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (w_load) begin
            w_data_d     = win_word(w_start_d);
            w_last_d     = (w_idx_d == w_last_idx_d);
            w_past_end_d = ((w_start_d + ADDR_W'(WIN_W)) > ADDR_W'(TBL_W));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= StIdle;
            r_start    <= '0;
            r_idx      <= '0;
            r_last_idx <= '0;
            r_data     <= '0;
            r_last     <= 1'b0;
            r_past_end <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_start    <= w_start_d;
            r_idx      <= w_idx_d;
            r_last_idx <= w_last_idx_d;
            r_data     <= w_data_d;
            r_last     <= w_last_d;
            r_past_end <= w_past_end_d;
        end
    end

    assign req_ready    = (r_state == StIdle);
    assign busy         = (r_state == StStream);
    assign out_valid    = (r_state == StStream);
    assign out_data     = r_data;
    assign out_index    = r_idx;
    assign out_last     = r_last;
    assign out_past_end = r_past_end;

endmodule

// File: tb/tb_fpu_two_over_pi_window.sv
// Scoreboard bench: directed requests push expected words; a monitor pops on each handshake.
module tb_fpu_two_over_pi_window;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [8:0]  req_offset;
    logic [3:0]  req_count;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  out_index;
    logic        out_last;
    logic        out_past_end;
    logic        busy;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  idx;
        logic        last;
        logic        pe;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [63:0] W0 = 64'hA2F9836E4E441529;
    localparam logic [63:0] W1 = 64'hFC2757D1F534DDC0;
    localparam logic [63:0] W2 = 64'hDB6295993C439041;
    localparam logic [63:0] W3 = 64'hFE5163ABDEBBC561;

    fpu_two_over_pi_window #(
        .WIN_W(64),
        .MAX_WORDS(4),
        .OFS_W(9),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_offset(req_offset),
        .req_count(req_count),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_index(out_index),
        .out_last(out_last),
        .out_past_end(out_past_end),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] d, input logic [3:0] i, input logic l,
                        input logic p);
        exp_t e;
        e.data = d; e.idx = i; e.last = l; e.pe = p;
        q.push_back(e);
    endtask

    // Monitor: inputs change just after posedge, so a negedge sample predicts the handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_word", out_data, 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("word_data", out_data, e.data);
                check("word_index", 64'(out_index), 64'(e.idx));
                check("word_last", 64'(out_last), 64'(e.last));
                check("word_past_end", 64'(out_past_end), 64'(e.pe));
            end
        end
    end

    task automatic send(input logic [8:0] ofs, input logic [3:0] cnt);
        int budget;
        budget = 0;
        req_offset = ofs;
        req_count  = cnt;
        req_valid  = 1'b1;
        do begin
            @(negedge clk);
            budget++;
        end while (!req_ready && budget < 200);
        if (!req_ready) check("accept_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((q.size() != 0 || !req_ready) && budget < 200) begin
            @(posedge clk);
            #1;
            budget++;
        end
        check("drain_done", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] held;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_offset = '0;
        req_count  = '0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_index", 64'(out_index), 64'd0);
        check("rst_last_pe", 64'({out_last, out_past_end}), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single word at offset 0; idle again the cycle after the handshake.
        push(W0, 4'd0, 1'b1, 1'b0);
        send(9'd0, 4'd1);
        check("word0_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1;
        check("ready_after_last", 64'(req_ready), 64'd1);
        drain();

        push(64'h2F9836E4E441529F, 4'd0, 1'b1, 1'b0);
        send(9'd4, 4'd1);
        drain();

        push(64'h9FC2757D1F534DDC, 4'd0, 1'b1, 1'b0);
        send(9'd60, 4'd1);
        drain();

        // Three words back to back, one per cycle.
        push(W1, 4'd0, 1'b0, 1'b0);
        push(W2, 4'd1, 1'b0, 1'b0);
        push(W3, 4'd2, 1'b1, 1'b0);
        send(9'd64, 4'd3);
        repeat (3) @(posedge clk);
        #1;
        check("burst3_done_ready", 64'(req_ready), 64'd1);
        drain();

        push(64'hDEBBC56100000000, 4'd0, 1'b0, 1'b1);
        push(64'h0, 4'd1, 1'b1, 1'b1);
        send(9'd224, 4'd2);
        drain();

        push(64'h0, 4'd0, 1'b1, 1'b1);
        send(9'd300, 4'd1);
        drain();

        push(W0, 4'd0, 1'b1, 1'b0);
        send(9'd0, 4'd0);
        drain();

        push(W0, 4'd0, 1'b0, 1'b0);
        push(W1, 4'd1, 1'b0, 1'b0);
        push(W2, 4'd2, 1'b0, 1'b0);
        push(W3, 4'd3, 1'b1, 1'b0);
        send(9'd0, 4'd9);
        drain();

        // Backpressure with a second request waiting behind the burst.
        out_ready = 1'b0;
        push(W0, 4'd0, 1'b0, 1'b0);
        push(W1, 4'd1, 1'b1, 1'b0);
        send(9'd0, 4'd2);
        held = out_data;
        push(W2, 4'd0, 1'b1, 1'b0);
        fork
            send(9'd128, 4'd1);
        join_none
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", out_data, held);
            check("stall_index", 64'(out_index), 64'd0);
            check("stall_busy", 64'(req_ready), 64'd0);
        end
        check("stall_data_w0", held, W0);
        out_ready = 1'b1;
        wait (req_valid == 1'b0);
        drain();

        // Reset during index 1 of a 4-word burst.
        push(W0, 4'd0, 1'b0, 1'b0);
        push(W1, 4'd1, 1'b0, 1'b0);
        push(W2, 4'd2, 1'b0, 1'b0);
        push(W3, 4'd3, 1'b1, 1'b0);
        send(9'd0, 4'd4);
        @(posedge clk);
        #1;
        check("pre_reset_index", 64'(out_index), 64'd1);
        reset = 1'b1;
        #1;
        q.delete();
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_ready", 64'(req_ready), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        check("mid_rst_index", 64'(out_index), 64'd0);
        check("mid_rst_last_pe", 64'({out_last, out_past_end}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_word", 64'(out_valid), 64'd0);
        end
        check("post_rst_ready", 64'(req_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fpu_two_over_pi_window.md
# fpu_two_over_pi_window

Streaming bit-window generator for extended-precision range reduction (FPTAN/FSIN/FCOS argument reduction). It holds the first 256 fractional bits of 2/π and, on request, emits a burst of consecutive WIN_W-bit words starting at an arbitrary bit offset, with valid/ready backpressure. Microcode and the Payne-Hanek multiplier request exactly the slice of 2/π aligned to the operand exponent, so they no longer shift fixed 64-bit chunks themselves.

## Interface
- WIN_W, 64: output word width in bits (legal 8..128).
- MAX_WORDS, 4: maximum words per burst (legal 1..8).
- OFS_W, 9: offset width. Offsets 256..2^OFS_W-1 are legal and read as all-zero.
- CNT_W, 4: request count width. Must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  burst request present.
- req_ready  out  1  block idle and able to accept a request.
- req_offset  in  OFS_W  start bit position p0.
- req_count  in  CNT_W  number of words requested.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WIN_W  window word.
- out_index  out  CNT_W  0-based index of the word within the burst.
- out_last  out  1  current word is the final word of the burst.
- out_past_end  out  1  word contains at least one bit position of 256 or above.
- busy  out  1  burst in progress (equals !req_ready).

## Operation
- Table constant, MSB first: 2/π = 0.A2F9836E4E441529 FC2757D1F534DDC0 DB6295993C439041 FE5163ABDEBBC561 (hex).
- Bit position p has weight 2^-(p+1). Position 0 is the table MSB (1).
- Word k of a burst covers positions p0+k·WIN_W through p0+k·WIN_W+WIN_W-1.
  - Position p0+k·WIN_W maps to out_data[WIN_W-1].
  - Any position of 256 or above reads as 0.
- Offset arithmetic is at least OFS_W+log2(MAX_WORDS·WIN_W) bits wide, so it cannot wrap.
- Effective count:
  - req_count of 0 is treated as 1.
  - req_count above MAX_WORDS is clamped to MAX_WORDS.
- FSM has two states.
  - IDLE: req_ready=1, out_valid=0. A cycle with req_valid=1 accepts the request: it latches the offset and effective count, clears the word index, loads word 0 into the output register, and moves to STREAM.
  - STREAM: req_ready=0, out_valid=1. A cycle with out_valid&out_ready retires the word.
    - If out_last=1, go to IDLE and drop out_valid.
    - Otherwise increment the index and load the next word into the output register.
- A request presented while the block is busy is not accepted. The requester must hold it until req_ready=1.
- All outputs are registered. out_data, out_index, out_last and out_past_end are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: req_ready=1, busy=0, out_valid=0, out_data=0, out_index=0, out_last=0, out_past_end=0. The FSM returns to IDLE.
- Reset asserted mid-burst aborts the burst immediately. No further words are emitted after reset is released.
- Latency:
  - Request accepted at edge T: word 0 is valid after edge T.
  - With out_ready held high, one word per cycle. A burst of N words occupies N cycles of out_valid.
- The final word retires at edge R. req_ready=1 after edge R. The next request can be accepted at edge R+1, which gives one idle bubble between bursts.
- out_ready is ignored while out_valid=0.

## Test plan
- Basic reads (WIN_W=64):
  - Reset, then offset=0, count=1 -> out_data=A2F9836E4E441529, out_last=1, out_past_end=0, req_ready high the cycle after the handshake.
  - Offset=4, count=1 -> 2F9836E4E441529F.
- Offset=64, count=3 with out_ready held high -> FC2757D1F534DDC0, DB6295993C439041, FE5163ABDEBBC561 on consecutive cycles. Indices 0, 1, 2. out_last only on index 2.
- End of table:
  - Offset=224, count=2 -> DEBBC56100000000 with past_end=1, then 0000000000000000 with past_end=1 and last=1.
  - Offset=300 -> all-zero word with past_end=1.
- Count handling: count=0 -> exactly one word. count=9 with MAX_WORDS=4 -> exactly 4 words.
- Backpressure and busy:
  - Offset=0, count=2, out_ready low for 3 cycles -> word 0 held stable, out_valid stays high.
  - A second req_valid during the burst is not accepted until after out_last retires.
- Reset mid-burst: assert reset during index 1 of a 4-word burst -> all outputs reach reset values immediately. After release, req_ready=1 and no stale words appear.
